// File: rtl/approx_arith_pkg.sv
// rtl/approx_arith_pkg.sv - shared arithmetic types and saturating add for the approximate datapath
package approx_arith_pkg;

  localparam int PROD_W = 16;

  typedef enum logic {
    ACCUM = 1'b0,
    FLUSH = 1'b1
  } state_t;

  typedef struct packed {
    logic [63:0] sum;
    logic        sat;
  } sat_res_t;

  // Adds three unsigned operands and clamps to w bits; a set sat_in forces the clamp.
  // Two guard bits above the widest operand catch the carry of a three-way add.
  function automatic sat_res_t sat_add(
    input logic [63:0] a,
    input logic [63:0] b,
    input logic [63:0] c,
    input logic        sat_in,
    input int unsigned w
  );
    logic [65:0] t;
    logic [65:0] lim;
    sat_res_t    r;
    t   = {2'b00, a} + {2'b00, b} + {2'b00, c};
    lim = (66'd1 << w) - 66'd1;
    if (sat_in || (t > lim)) begin
      r.sum = lim[63:0];
      r.sat = 1'b1;
    end else begin
      r.sum = t[63:0];
      r.sat = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/approx_mac_accum_if.sv
// rtl/approx_mac_accum_if.sv - product input stream and result output stream of the accumulator
interface approx_mac_accum_if
  import approx_arith_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) ();

  logic              in_valid;
  logic              in_ready;
  logic [PROD_W-1:0] in_prod;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_sat;
  logic [CNT_W-1:0]  out_cnt;

  modport slave (
    input  in_valid, in_prod, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_sat, out_cnt
  );

  modport master (
    output in_valid, in_prod, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_sat, out_cnt
  );

endinterface

// File: rtl/approx_sat_adder.sv
// rtl/approx_sat_adder.sv - combinational acc + product + bias with sticky saturation
module approx_sat_adder
  import approx_arith_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic [ACC_W-1:0]  i_acc,
  input  logic [PROD_W-1:0] i_prod,
  input  logic [PROD_W-1:0] i_bias,
  input  logic              i_sat,
  output logic [ACC_W-1:0]  o_sum,
  output logic              o_sat
);

  sat_res_t w_res;

  // Single ripple add plus clamp mux, no internal register.
  always_comb begin
    w_res = sat_add(64'(i_acc), 64'(i_prod), 64'(i_bias), i_sat, ACC_W);
  end

  assign o_sum = w_res.sum[ACC_W-1:0];
  // Bits above ACC_W are zero by construction; folding them in keeps the whole result consumed.
  assign o_sat = w_res.sat | (|w_res.sum[63:ACC_W]);

endmodule

// File: rtl/approx_mac_accum.sv
// rtl/approx_mac_accum.sv - saturating per-vector accumulator with bias, count and result register
module approx_mac_accum
  import approx_arith_pkg::*;
#(
  parameter int                ACC_W = 24,
  parameter int                CNT_W = 8,
  parameter logic [PROD_W-1:0] BIAS  = '0
) (
  input logic               clk,
  input logic               rst,
  approx_mac_accum_if.slave bus
);

  state_t           r_state;
  state_t           w_state_next;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;
  logic [ACC_W-1:0] r_out_sum;
  logic [CNT_W-1:0] r_out_cnt;
  logic             r_out_sat;
  logic [ACC_W-1:0] w_sum;
  logic             w_sat;
  logic [CNT_W-1:0] w_cnt_next;
  logic             w_in_ready;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_load;

  // A result is pending exactly while in FLUSH; in_ready only looks at that and out_ready.
  assign bus.out_valid = (r_state == FLUSH);
  assign w_in_ready    = (r_state == ACCUM) || bus.out_ready;
  assign bus.in_ready  = w_in_ready;
  assign w_in_fire     = bus.in_valid && w_in_ready;
  assign w_out_fire    = (r_state == FLUSH) && bus.out_ready;

  assign bus.out_sum = r_out_sum;
  assign bus.out_sat = r_out_sat;
  assign bus.out_cnt = r_out_cnt;

  approx_sat_adder #(
    .ACC_W(ACC_W)
  ) u_adder (
    .i_acc  (r_acc),
    .i_prod (bus.in_prod),
    .i_bias (BIAS),
    .i_sat  (r_sat),
    .o_sum  (w_sum),
    .o_sat  (w_sat)
  );

  // Element counter sticks at all ones instead of wrapping.
  assign w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: a last-accept always (re)loads the result, else a drained result returns to ACCUM.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    case (r_state)
      ACCUM: begin
        if (w_in_fire && bus.in_last) begin
          w_load       = 1'b1;
          w_state_next = FLUSH;
        end
      end
      FLUSH: begin
        if (w_in_fire && bus.in_last) begin
          w_load = 1'b1;
        end else if (w_out_fire) begin
          w_state_next = ACCUM;
        end
      end
      default: w_state_next = ACCUM;
    endcase
  end

  // Running accumulator, count and sticky flag; cleared when a vector closes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else if (w_in_fire) begin
      if (bus.in_last) begin
        r_acc <= '0;
        r_cnt <= '0;
        r_sat <= 1'b0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= w_cnt_next;
        r_sat <= w_sat;
      end
    end
  end

  // Result register captures the post-update values and holds them until the next load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_sum <= '0;
      r_out_sat <= 1'b0;
      r_out_cnt <= '0;
    end else if (w_load) begin
      r_out_sum <= w_sum;
      r_out_sat <= w_sat;
      r_out_cnt <= w_cnt_next;
    end
  end

endmodule

// File: doc/approx_mac_accum.md
# approx_mac_accum

Downstream accumulation stage for the 8x8 approximate unsigned multipliers: consumes a stream of 16-bit products and sums each vector, delimited by a last flag, into a saturating accumulator. The stage adds an optional per-product bias to compensate the multiplier's mean error, then emits one result per vector with a sticky saturation flag and an element count. It sits between the multiplier output and the FPGA-side result FIFO in the dot-product datapath.

## Interface
- ACC_W, 24, accumulator/result width; must be ≥ 17.
- CNT_W, 8, element-counter width.
- BIAS, 0, unsigned 16-bit constant added to every accepted product (mean-error compensation).

- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  product valid.
- in_ready  out  1  stage can accept a product.
- in_prod  in  16  unsigned product from the multiplier.
- in_last  in  1  product is the final element of the vector.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  ACC_W  vector sum, saturated.
- out_sat  out  1  saturation occurred at any point in this vector.
- out_cnt  out  CNT_W  elements in the vector, saturated at 2^CNT_W−1.

## Operation
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- in_ready = !out_valid || out_ready, purely from the registered out_valid and out_ready; it never depends on in_valid or in_last.
- Two states:
  - ACCUM: collecting elements. This is the reset state.
  - FLUSH: a result is held on the output with out_valid=1.
- Per accepted element, compute t = acc + in_prod + BIAS at ACC_W+2 bits.
  - If t > 2^ACC_W−1 or sat_r is already set: next acc = all ones and sat_r is set.
  - Otherwise next acc = t[ACC_W−1:0].
- Per accepted element, cnt increments and saturates at all ones; it does not wrap.
- Accepted element with in_last=1:
  - out_sum, out_sat and out_cnt load the post-update values.
  - out_valid goes to 1.
  - acc, cnt and sat_r clear to 0.
  - State moves to FLUSH.
- Output transfer with no simultaneous last-accept: out_valid goes to 0 and state returns to ACCUM.
- Output transfer in the same cycle as a new last-accept: the new result loads, out_valid stays 1, and state stays FLUSH. This is back-to-back operation with no bubble.
- Non-last elements may be accepted in FLUSH only when out_ready=1 that cycle, which follows from the in_ready rule.
- A single-element vector (in_last on the first element) yields sum = prod + BIAS and cnt = 1.
- Reset mid-vector discards the partial sum and any pending result. No output is produced.

## Timing
- Reset values: in_ready=1, out_valid=0, out_sum=0, out_sat=0, out_cnt=0. Internal acc, cnt and sat_r are 0; state is ACCUM.
- Latency: out_valid rises the cycle after the last-element accept.
- Throughput: 1 element/cycle sustained while out_ready=1.
- Output stability: out_sum, out_sat and out_cnt hold stable while out_valid && !out_ready.
- Combinational paths: none from in_* to out_*. The only combinational path is out_ready → in_ready.
- Adder depth: one ACC_W+2 ripple add plus a saturation mux. No pipeline register inside the adder.

## Structure
- Shared package approx_arith_pkg holds:
  - PROD_W=16;
  - the state enum {ACCUM, FLUSH};
  - a sat_add function (width-parametric saturating add). The same function is used by the neighbouring stages.
- One sub-module, approx_sat_adder. It is combinational: it takes (acc, prod, bias, sat_in) and produces (sum, sat_out). The bench tests it standalone.
- The FSM, counters and the output register live in the top level.

## Test plan
- Sum and count: BIAS=0; products 100, 200, 300 with last on 300; out_ready=1.
  - Required: out_sum=600, out_cnt=3, out_sat=0, and out_valid one cycle after the third accept.
- Bias compensation: BIAS=104; two products of 1000 with last on the second.
  - Required: out_sum=2208, out_cnt=2.
- Saturation: ACC_W=17; products 65025, 65025, 65025, 1 with last on 1.
  - Required: out_sum=131071, out_sat=1.
  - The next vector [5] (last) gives out_sum=5, out_sat=0.
- Backpressure: result pending with out_ready=0 for 5 cycles.
  - Required: in_ready=0 throughout and outputs stable.
  - When out_ready rises, in_ready=1 in the same cycle; a simultaneous last-accept loads the new result with out_valid staying 1.
- Count saturation and mid-vector reset:
  - CNT_W=2; 5 products, last on the fifth. Required: out_cnt=3.
  - Separately, assert rst after 2 of 3 elements. Required: all outputs 0, no out_valid.
  - A following vector [7] (last) gives out_sum=7, out_cnt=1.
